// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, alignment FSM states and
// default alignment/lock timing constants.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam int unsigned DEFAULT_SLIP_TIMEOUT = 64;
  localparam int unsigned DEFAULT_LOCK_COUNT   = 16;
  localparam int unsigned DEFAULT_LOSS_TIMEOUT = 4096;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: 10-bit aligned symbol to 8-bit video
// data, 2-bit control code and a control-token flag.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       is_ctrl
);

  logic [7:0] d;

  always_comb begin
    d     = sym[7:0] ^ {8{sym[9]}};
    vd    = '0;
    vd[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      vd[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    cd      = '0;
    is_ctrl = 1'b1;
    case (sym)
      CTRL_TOKEN_00: cd = 2'b00;
      CTRL_TOKEN_01: cd = 2'b01;
      CTRL_TOKEN_10: cd = 2'b10;
      CTRL_TOKEN_11: cd = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS receiver: word alignment search with lock tracking,
// followed by a two-stage decode pipeline.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned SLIP_TIMEOUT = DEFAULT_SLIP_TIMEOUT,
  parameter int unsigned LOCK_COUNT   = DEFAULT_LOCK_COUNT,
  parameter int unsigned LOSS_TIMEOUT = DEFAULT_LOSS_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned GAP_LIMIT = (SLIP_TIMEOUT > LOSS_TIMEOUT) ? SLIP_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

  align_state_t state, state_next;
  logic [RUN_W-1:0] run_cnt, run_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [3:0]       offset_next;

  logic [9:0]  prev;
  logic [19:0] window;
  logic [9:0]  aligned;
  logic [7:0]  dec_vd;
  logic [1:0]  dec_cd;
  logic        dec_ctrl;

  logic [7:0]  s1_vd;
  logic [1:0]  s1_cd;
  logic        s1_ctrl;
  logic        s1_valid;

  assign window  = {sym_in, prev};
  assign aligned = 10'(window >> offset);
  assign locked  = (state == LOCKED);

  tmds_symbol_decode u_decode (
    .sym     (aligned),
    .vd      (dec_vd),
    .cd      (dec_cd),
    .is_ctrl (dec_ctrl)
  );

  // Stage 1 carries the decoded fields instead of the raw aligned symbol;
  // stage-2 outputs are identical either way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      s1_vd    <= '0;
      s1_cd    <= '0;
      s1_ctrl  <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sym_valid;
      if (sym_valid) begin
        prev    <= sym_in;
        s1_vd   <= dec_vd;
        s1_cd   <= dec_cd;
        s1_ctrl <= dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VD        <= '0;
      CD        <= '0;
      VDE       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid && locked;
      if (s1_valid) begin
        VD  <= s1_vd;
        CD  <= s1_cd;
        VDE <= ~s1_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      run_cnt <= '0;
      gap_cnt <= '0;
      offset  <= '0;
    end else begin
      state   <= state_next;
      run_cnt <= run_next;
      gap_cnt <= gap_next;
      offset  <= offset_next;
    end
  end

  // A control token is tested before any timeout so it always wins a tie.
  always_comb begin
    state_next  = state;
    run_next    = run_cnt;
    gap_next    = gap_cnt;
    offset_next = offset;
    if (s1_valid) begin
      case (state)
        SEARCH: begin
          if (s1_ctrl) begin
            gap_next = '0;
            if (run_cnt >= RUN_W'(LOCK_COUNT - 1)) begin
              state_next = LOCKED;
              run_next   = '0;
            end else begin
              run_next = run_cnt + RUN_W'(1);
            end
          end else begin
            run_next = '0;
            if (gap_cnt >= GAP_W'(SLIP_TIMEOUT - 1)) begin
              gap_next    = '0;
              offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            end else begin
              gap_next = gap_cnt + GAP_W'(1);
            end
          end
        end
        LOCKED: begin
          if (s1_ctrl) begin
            gap_next = '0;
          end else if (gap_cnt >= GAP_W'(LOSS_TIMEOUT - 1)) begin
            state_next = SEARCH;
            gap_next   = '0;
            run_next   = '0;
          end else begin
            gap_next = (gap_cnt == '1) ? gap_cnt : gap_cnt + GAP_W'(1);
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed self-checking bench for tmds_channel_decoder: reset, lock
// acquisition, data/control decode, skewed alignment, loss of lock, valid gaps.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       out_valid;
  logic       locked;
  logic [3:0] offset;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .SLIP_TIMEOUT (64),
    .LOCK_COUNT   (16),
    .LOSS_TIMEOUT (4096)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .VD        (VD),
    .CD        (CD),
    .VDE       (VDE),
    .out_valid (out_valid),
    .locked    (locked),
    .offset    (offset)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_vd"},        16'(VD),        16'h0);
    check_eq({tag, "_cd"},        16'(CD),        16'h0);
    check_eq({tag, "_vde"},       16'(VDE),       16'h0);
    check_eq({tag, "_out_valid"}, 16'(out_valid), 16'h0);
    check_eq({tag, "_locked"},    16'(locked),    16'h0);
    check_eq({tag, "_offset"},    16'(offset),    16'h0);
  endtask

  task automatic drive(input logic [9:0] s, input logic v);
    @(negedge clk);
    sym_in    = s;
    sym_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_idle(tag);
    @(negedge clk);
    reset     = 1'b0;
    sym_valid = 1'b0;
  endtask

  logic [9:0] tok;
  logic [9:0] skew_word;
  int         lock_at;
  int         early;
  logic [3:0] off64, off65;

  initial begin
    reset     = 1'b1;
    sym_in    = '0;
    sym_valid = 1'b0;
    #2;
    check_idle("por");
    @(negedge clk);
    reset = 1'b0;

    // Aligned lock at offset 0: the aligned word is the previous sample.
    for (int n = 1; n <= 19; n++) begin
      drive(CTRL_TOKEN_00, 1'b1);
      if (n == 17) check_eq("lock_not_yet", 16'(locked), 16'h0);
      if (n == 18) begin
        check_eq("lock_rise", 16'(locked), 16'h1);
        check_eq("lock_offset", 16'(offset), 16'h0);
      end
    end
    check_eq("tok_out_valid", 16'(out_valid), 16'h1);
    check_eq("tok_vde", 16'(VDE), 16'h0);
    check_eq("tok_cd", 16'(CD), 16'h0);

    // Decode: outputs for the symbol driven at k appear after drive k+2.
    drive(10'h100, 1'b1);
    drive(10'h200, 1'b1);
    drive(CTRL_TOKEN_11, 1'b1);
    check_eq("d100_vd", 16'(VD), 16'h00);
    check_eq("d100_vde", 16'(VDE), 16'h1);
    check_eq("d100_ov", 16'(out_valid), 16'h1);
    drive(10'h2F0, 1'b1);
    check_eq("d200_vd", 16'(VD), 16'hFF);
    check_eq("d200_vde", 16'(VDE), 16'h1);
    drive(10'h1AA, 1'b1);
    check_eq("c11_cd", 16'(CD), 16'h3);
    check_eq("c11_vde", 16'(VDE), 16'h0);
    drive(CTRL_TOKEN_00, 1'b1);
    check_eq("d2f0_vd", 16'(VD), 16'hEF);
    drive(CTRL_TOKEN_00, 1'b1);
    check_eq("d1aa_vd", 16'(VD), 16'hFE);
    drive(CTRL_TOKEN_00, 1'b1);
    check_eq("c00_cd", 16'(CD), 16'h0);
    check_eq("c00_vde", 16'(VDE), 16'h0);

    // Loss of lock: token exactly on the 4096th symbol keeps lock.
    for (int i = 1; i <= 4095; i++) drive(10'h100, 1'b1);
    drive(CTRL_TOKEN_00, 1'b1);
    for (int d = 1; d <= 4099; d++) begin
      drive(10'h100, 1'b1);
      if (d == 2)    check_eq("token_on_limit", 16'(locked), 16'h1);
      if (d == 4097) check_eq("loss_not_yet", 16'(locked), 16'h1);
      if (d == 4098) begin
        check_eq("loss_fall", 16'(locked), 16'h0);
        check_eq("loss_offset", 16'(offset), 16'h0);
        check_eq("loss_last_ov", 16'(out_valid), 16'h1);
      end
      if (d == 4099) check_eq("loss_ov", 16'(out_valid), 16'h0);
    end

    pulse_reset("rst_a");

    // Skewed stream: word bit j is token bit (j+3) mod 10, so lock lands at offset 7.
    tok = CTRL_TOKEN_10;
    for (int j = 0; j < 10; j++) skew_word[j] = tok[(j + 3) % 10];
    lock_at = 0;
    early   = 0;
    off64   = '1;
    off65   = '1;
    for (int n = 1; n <= 467; n++) begin
      drive(skew_word, 1'b1);
      if (n == 64) off64 = offset;
      if (n == 65) off65 = offset;
      if (locked && lock_at == 0) lock_at = n;
      if (out_valid && (lock_at == 0 || lock_at == n)) early++;
    end
    check_eq("skew_off64", 16'(off64), 16'h0);
    check_eq("skew_off65", 16'(off65), 16'h1);
    check_eq("skew_lock_at", 16'(lock_at), 16'd466);
    check_eq("skew_offset", 16'(offset), 16'h7);
    check_eq("skew_early_ov", 16'(early), 16'h0);
    check_eq("skew_ov", 16'(out_valid), 16'h1);
    check_eq("skew_cd", 16'(CD), 16'h2);
    check_eq("skew_vde", 16'(VDE), 16'h0);

    pulse_reset("rst_b");

    // Valid gaps: invalid cycles carry a data word that must be ignored.
    for (int n = 1; n <= 36; n++) begin
      if (n % 2 == 1) drive(CTRL_TOKEN_00, 1'b1);
      else            drive(10'h100, 1'b0);
      if (n == 33) check_eq("gap_lock_not_yet", 16'(locked), 16'h0);
      if (n == 34) check_eq("gap_lock_rise", 16'(locked), 16'h1);
      if (n == 35) check_eq("gap_ov_low", 16'(out_valid), 16'h0);
      if (n == 36) begin
        check_eq("gap_ov_high", 16'(out_valid), 16'h1);
        check_eq("gap_cd", 16'(CD), 16'h0);
        check_eq("gap_vde", 16'(VDE), 16'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the per-channel TMDS encoder: recovers word alignment of a raw 10-bit TMDS symbol stream and decodes each symbol back to 8-bit video data or a 2-bit control code. One instance sits per colour channel behind the deserialiser in the HDMI/DVI input path. It also reports lock status, and its outputs feed the video timing recovery logic.

## Interface
- `SLIP_TIMEOUT`, default 64: symbols without a control token, while searching, before advancing the word offset.
- `LOCK_COUNT`, default 16: consecutive control tokens at the current offset required to declare lock.
- `LOSS_TIMEOUT`, default 4096: symbols without any control token, while locked, before lock is dropped.
- `clk` in 1: symbol clock.
- `reset` in 1: asynchronous, active-high.
- `sym_in` in 10: raw deserialised word; bit 0 is the first bit on the wire. Word boundary is unknown.
- `sym_valid` in 1: `sym_in` is valid this cycle.
- `VD` out 8: decoded video data.
- `CD` out 2: decoded control data.
- `VDE` out 1: 1 = current symbol is data (`VD` valid); 0 = control token (`CD` valid).
- `out_valid` out 1: `VD`/`CD`/`VDE` valid this cycle. Asserted only while locked.
- `locked` out 1: alignment lock.
- `offset` out 4: current bit offset, 0..9.

## Operation
- **Alignment window:** `prev` holds the last valid `sym_in`. Form `w = {sym_in, prev}` (20 bits). The aligned symbol is `a = w[offset +: 10]`.
- **Control tokens:** 10'b1101010100→CD 00, 10'b0010101011→01, 10'b0101010100→10, 10'b1010101011→11. Any other aligned word is data.
- **Data decode:** `d = a[7:0] ^ {8{a[9]}}`. `VD[0] = d[0]`. For i=1..7, `VD[i] = a[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`.
- **FSM SEARCH** (reset state):
  - `run_cnt` counts consecutive control tokens and `gap_cnt` counts symbols since the last control token.
  - A data symbol clears `run_cnt`.
  - `gap_cnt` reaching `SLIP_TIMEOUT` sets `offset <= (offset==9) ? 0 : offset+1` and clears both counters.
  - `run_cnt` reaching `LOCK_COUNT` moves the FSM to LOCKED.
- **FSM LOCKED:**
  - Each control token clears `gap_cnt`.
  - `gap_cnt` reaching `LOSS_TIMEOUT` moves the FSM to SEARCH and clears the counters. `offset` is retained.
- **Simultaneous events:** a control token in the same symbol that would hit a timeout wins. The counter clears and no slip or loss occurs.
- **sym_valid low:** `prev`, the counters, the FSM and `offset` hold. `out_valid` goes low at the matching output cycle.
- **Counter widths:** each counter is sized to its parameter and saturates, so it never wraps.

## Timing
- **Stage 1 (register):** aligned symbol, control/data classification, and the valid flag.
- **Stage 2 (register):** decoded `VD`, `CD`, `VDE`, `out_valid`.
- **Latency:** symbol on `sym_in` at edge N gives outputs at edge N+2.
- **FSM update:** from the stage-1 classification. `locked` rises the cycle after the `LOCK_COUNT`-th consecutive token is registered in stage 1.
- **`out_valid`:** equals stage-1 valid AND locked, registered.
- **Offset changes:** apply to the next valid `sym_in`. There are no output bubbles beyond those caused by `sym_valid`.
- **Reset:** asynchronous, clears everything.
  - `VD`=0, `CD`=0, `VDE`=0, `out_valid`=0, `locked`=0, `offset`=0.
  - `prev`=0, counters 0, FSM=SEARCH.
  - Reset mid-stream discards all pipeline contents, and lock must be reacquired.

## Structure
- **Package `tmds_pkg`:**
  - The four control-token constants (shared with the encoder).
  - The FSM state enum {SEARCH, LOCKED}.
  - The default timeout/lock constants.
- **Sub-module `tmds_symbol_decode`:** combinational, maps a 10-bit aligned symbol to `VD`, `CD`, `is_ctrl`. It is reusable by a future TERC4/guard-band extension.
- **Top level:** alignment window, counters, FSM, pipeline registers.

## Test plan
- **Reset:** assert `reset` mid-run → all outputs 0 asynchronously. `locked` reacquires only after 16 tokens post-release.
- **Aligned lock:** 16 × 10'b1101010100, `sym_valid`=1 → `locked`=1, `offset`=0. The following symbols give `out_valid`=1, `VDE`=0, `CD`=00, two cycles after each input.
- **Data decode:** once locked, 10'h100 → `VD`=8'h00, `VDE`=1. 10'h200 → `VD`=8'hFF. 10'b1010101011 → `CD`=11, `VDE`=0.
- **Skewed stream:** serial repetition of 10'b0101010100 framed with a 3-bit skew → offset steps every 64 symbols and wraps 9→0 if needed. Lock is declared at the offset where `CD`=10 decodes. No `out_valid` before lock.
- **Loss of lock:** locked, then 4096 data symbols with no token → `locked` falls, `out_valid`=0, `offset` unchanged. A token arriving exactly on symbol 4096 keeps lock.
- **Valid gaps:** `sym_valid` toggled 1/0 during lock acquisition → counters advance only on valid cycles. Lock still occurs after exactly 16 valid tokens.
